// File: rtl/sseg_bcd_mux.sv
// sseg_bcd_mux: time-multiplexed 4-digit seven-segment driver for a
// common-anode display fed by a packed BCD word.
// - The input word and decimal points are latched once per scan frame, so a
//   frame never shows a mix of old and new digits.
// - Anode and segment outputs are registered and active-low.
// - Optional build macro SSEG_LEADING_ZERO_BLANK_EN enables suppression of
//   leading zeros (digits 3..1) based on the latched word. Without it all
//   four digits are always driven.
module sseg_bcd_mux #(
    parameter int REFRESH_POWER = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_en,
    input  logic        blank,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick
);

    localparam logic [REFRESH_POWER-1:0] CNT_MAX  = {REFRESH_POWER{1'b1}};
    localparam logic [REFRESH_POWER-1:0] CNT_ZERO = {REFRESH_POWER{1'b0}};
    localparam logic [REFRESH_POWER-1:0] CNT_ONE  = {{(REFRESH_POWER-1){1'b0}}, 1'b1};

    // BCD nibble to active-low {g,f,e,d,c,b,a}; anything above 9 shows a dash.
    function automatic logic [6:0] enc7(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    logic [REFRESH_POWER-1:0] cnt_r;
    logic [15:0]              snap_r;
    logic [3:0]               dp_snap_r;
    logic [1:0]               sel_s;
    logic [3:0]               digit_s;
    logic                     lit_s;
    logic [3:0]               an_s;
    logic [7:0]               sseg_s;
    logic                     frame_start_s;

    assign sel_s         = cnt_r[REFRESH_POWER-1:REFRESH_POWER-2];
    assign frame_start_s = (cnt_r == CNT_ZERO);

    // Refresh counter and per-frame snapshot of the digit word and decimal points.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= CNT_ZERO;
            snap_r    <= 16'h0000;
            dp_snap_r <= 4'b0000;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
            if (cnt_r == CNT_MAX) begin
                snap_r    <= digits;
                dp_snap_r <= dp_en;
            end else begin
                snap_r    <= snap_r;
                dp_snap_r <= dp_snap_r;
            end
        end
    end

    // Pick the latched nibble belonging to the current scan slot.
    always_comb begin
        digit_s = 4'h0;
        case (sel_s)
            2'd0:    digit_s = snap_r[3:0];
            2'd1:    digit_s = snap_r[7:4];
            2'd2:    digit_s = snap_r[11:8];
            2'd3:    digit_s = snap_r[15:12];
            default: digit_s = 4'h0;
        endcase
    end

`ifdef SSEG_LEADING_ZERO_BLANK_EN
    logic [3:0] lz_mask_s;

    // Leading-zero chain: a digit is dark when it and every digit left of it are zero.
    always_comb begin
        lz_mask_s    = 4'b0000;
        lz_mask_s[3] = (snap_r[15:12] == 4'h0);
        lz_mask_s[2] = lz_mask_s[3] && (snap_r[11:8] == 4'h0);
        lz_mask_s[1] = lz_mask_s[2] && (snap_r[7:4] == 4'h0);
        lz_mask_s[0] = 1'b0;
        lit_s        = ~lz_mask_s[sel_s];
    end
`else
    assign lit_s = 1'b1;
`endif

    // Next anode/segment pattern; blanking (global or leading-zero) turns the slot dark.
    always_comb begin
        an_s   = 4'b1111;
        sseg_s = 8'hFF;
        if (blank || !lit_s) begin
            an_s   = 4'b1111;
            sseg_s = 8'hFF;
        end else begin
            an_s   = ~(4'b0001 << sel_s);
            sseg_s = {~dp_snap_r[sel_s], enc7(digit_s)};
        end
    end

    // Registered pin drivers and frame pulse (high while the counter sits at zero).
    always_ff @(posedge clk) begin
        if (reset) begin
            an         <= 4'b1111;
            sseg       <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            an         <= an_s;
            sseg       <= sseg_s;
            frame_tick <= frame_start_s;
        end
    end

endmodule

// File: tb/tb_sseg_bcd_mux.sv
// Self-checking bench for sseg_bcd_mux at REFRESH_POWER=4 (16-cycle frame,
// 4-cycle slots). A behavioural display model predicts the pins every cycle;
// literal expectations pin down the documented scenarios. Honours the
// SSEG_LEADING_ZERO_BLANK_EN macro the same way the design does.
module tb_sseg_bcd_mux;

    localparam int P        = 4;
    localparam int FRAME    = 1 << P;
    localparam int SLOT_LEN = FRAME / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp_en = 4'b0000;
    logic        blank = 1'b0;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    sseg_bcd_mux #(.REFRESH_POWER(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .digits     (digits),
        .dp_en      (dp_en),
        .blank      (blank),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    // Reference glyphs {g..a}, active-low, indexed by nibble value.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Behavioural model state: position in the frame and latched word.
    int          m_pos = 0;
    logic [15:0] m_word = 16'h0000;
    logic [3:0]  m_dp = 4'b0000;
    logic        m_valid = 1'b0;
    logic [3:0]  exp_an = 4'b1111;
    logic [7:0]  exp_sseg = 8'hFF;
    logic        exp_ft = 1'b0;

    // Model: which digit is scanned now, what it should look like next cycle.
    always @(posedge clk) begin
        int   slot;
        int   val;
        logic shown;
        if (reset) begin
            m_pos    <= 0;
            m_word   <= 16'h0000;
            m_dp     <= 4'b0000;
            exp_an   <= 4'b1111;
            exp_sseg <= 8'hFF;
            exp_ft   <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            slot = m_pos / SLOT_LEN;
            val  = int'((m_word >> (4 * slot)) & 16'h000F);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
            shown = (slot == 0) || ((m_word >> (4 * slot)) != 16'h0000);
`else
            shown = 1'b1;
`endif
            if (blank || !shown) begin
                exp_an   <= 4'b1111;
                exp_sseg <= 8'hFF;
            end else begin
                exp_an   <= 4'b1111 & ~(4'b0001 << slot);
                exp_sseg <= {~m_dp[slot], glyph[val]};
            end
            exp_ft <= (m_pos == 0);
            if (m_pos == FRAME - 1) begin
                m_word <= digits;
                m_dp   <= dp_en;
            end
            m_pos <= (m_pos + 1) % FRAME;
        end
    end

    // Compare process: DUT pins against the model on every falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            total++;
            if (an !== exp_an || sseg !== exp_sseg || frame_tick !== exp_ft) begin
                bad++;
                $display("FAIL model t=%0t: got an=%b sseg=%h ft=%b, expected an=%b sseg=%h ft=%b",
                         $time, an, sseg, frame_tick, exp_an, exp_sseg, exp_ft);
            end
        end
    end

    task automatic steps(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset two cycles, release at a falling edge (that edge is "edge 0").
    task automatic do_reset();
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic lit(input string nm, input logic [3:0] a, input logic [7:0] s, input logic f);
        total++;
        if (an !== a || sseg !== s || frame_tick !== f) begin
            bad++;
            $display("FAIL %s: got an=%b sseg=%h ft=%b, expected an=%b sseg=%h ft=%b",
                     nm, an, sseg, frame_tick, a, s, f);
        end
    endtask

    initial begin
        // Scenario 1: 1234 after reset; first frame shows the cleared snapshot.
        digits = 16'h1234;
        dp_en  = 4'b0000;
        do_reset();
        steps(1);  lit("first_edge", 4'b1110, 8'hC0, 1'b1);
        steps(1);  lit("tick_low",   4'b1110, 8'hC0, 1'b0);
        steps(15); lit("f2_slot0",   4'b1110, 8'h99, 1'b1);
        steps(4);  lit("f2_slot1",   4'b1101, 8'hB0, 1'b0);
        steps(4);  lit("f2_slot2",   4'b1011, 8'hA4, 1'b0);
        steps(4);  lit("f2_slot3",   4'b0111, 8'hF9, 1'b0);
        // Mid-frame change to 5678: current frame keeps 1234.
        digits = 16'h5678;
        steps(3);  lit("no_tear",    4'b0111, 8'hF9, 1'b0);
        steps(1);  lit("new_slot0",  4'b1110, 8'h80, 1'b1);
        steps(12); lit("new_slot3",  4'b0111, 8'h92, 1'b0);

        // Scenario 2: 00A7 with dp on digit 1, then a 5-cycle blank.
        digits = 16'h00A7;
        dp_en  = 4'b0010;
        do_reset();
        steps(17); lit("a7_d0",      4'b1110, 8'hF8, 1'b1);
        steps(4);  lit("a7_d1_dash", 4'b1101, 8'h3F, 1'b0);
        steps(4);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        lit("a7_d2", 4'b1111, 8'hFF, 1'b0);
`else
        lit("a7_d2", 4'b1011, 8'hC0, 1'b0);
`endif
        blank = 1'b1;
        steps(1);  lit("blank_on",   4'b1111, 8'hFF, 1'b0);
        steps(4);  lit("blank_hold", 4'b1111, 8'hFF, 1'b0);
        blank = 1'b0;
        steps(1);
`ifdef SSEG_LEADING_ZERO_BLANK_EN
        lit("blank_resume", 4'b1111, 8'hFF, 1'b0);
`else
        lit("blank_resume", 4'b0111, 8'hC0, 1'b0);
`endif
        steps(2);  lit("blank_next", 4'b1110, 8'hF8, 1'b1);

`ifdef SSEG_LEADING_ZERO_BLANK_EN
        // Leading-zero suppression cases.
        digits = 16'h0000;
        dp_en  = 4'b0000;
        do_reset();
        steps(17); lit("lz0_d0", 4'b1110, 8'hC0, 1'b1);
        steps(4);  lit("lz0_d1", 4'b1111, 8'hFF, 1'b0);
        digits = 16'h0900;
        do_reset();
        steps(17); lit("lz9_d0", 4'b1110, 8'hC0, 1'b1);
        steps(4);  lit("lz9_d1", 4'b1101, 8'hC0, 1'b0);
        steps(4);  lit("lz9_d2", 4'b1011, 8'h90, 1'b0);
        steps(4);  lit("lz9_d3", 4'b1111, 8'hFF, 1'b0);
`endif

        // Scenario 3: reset mid-frame with 9999.
        digits = 16'h9999;
        dp_en  = 4'b0000;
        do_reset();
        steps(20);
        reset = 1'b1;
        steps(1);  lit("rst_mid",      4'b1111, 8'hFF, 1'b0);
        reset = 1'b0;
        steps(1);  lit("rst_first",    4'b1110, 8'hC0, 1'b1);
        steps(16); lit("rst_f2_slot0", 4'b1110, 8'h90, 1'b1);

        // Randomized phase: model-checked every cycle.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 7) == 0) begin
                    digits = 16'($urandom);
                end else begin
                    digits = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                              4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                    if ($urandom_range(0, 2) == 0) begin
                        digits = digits & (16'hFFFF >> (4 * $urandom_range(1, 3)));
                    end
                end
            end
            if ($urandom_range(0, 29) == 0) dp_en = 4'($urandom);
            blank = ($urandom_range(0, 24) == 0) ? 1'b1 : (blank && $urandom_range(0, 2) != 0);
            reset = ($urandom_range(0, 399) == 0);
            steps(1);
        end
        reset = 1'b0;
        blank = 1'b0;
        steps(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
